// File: rtl/std_bit_scan_encoder.sv
// Multi-hit unary-to-binary encoder: serialises every set bit of a vector as one index beat.
// Optional STD_BIT_SCAN_ENCODER_COUNT_EN adds o_count (beats remaining, incl. current).
module std_bit_scan_encoder #(
    parameter int UNARY_WIDTH = 256,
    parameter int BIN_WIDTH   = $clog2(UNARY_WIDTH),
    parameter bit LSB_FIRST   = 1'b1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [UNARY_WIDTH-1:0] i_unary,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [BIN_WIDTH-1:0]   o_bin,
    output logic                   o_last,
    output logic                   o_zero
`ifdef STD_BIT_SCAN_ENCODER_COUNT_EN
    ,
    output logic [BIN_WIDTH:0]     o_count
`endif
);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    localparam logic [UNARY_WIDTH-1:0] PEND_ONE = UNARY_WIDTH'(1);

    state_t                 state;
    logic [UNARY_WIDTH-1:0] pend;
    logic [UNARY_WIDTH-1:0] clr_mask;
    logic                   zflag;
    logic [BIN_WIDTH-1:0]   hit_idx;
    logic                   single;
    logic                   accept;
    logic                   beat;

    // Later loop iterations win, so the scan direction picks lowest or highest.
    always_comb begin
        hit_idx = '0;
        if (LSB_FIRST) begin
            for (int i = UNARY_WIDTH - 1; i >= 0; i--) begin
                if (pend[i]) hit_idx = BIN_WIDTH'(i);
            end
        end else begin
            for (int i = 0; i < UNARY_WIDTH; i++) begin
                if (pend[i]) hit_idx = BIN_WIDTH'(i);
            end
        end
    end

    always_comb begin
        clr_mask          = '0;
        clr_mask[hit_idx] = 1'b1;
    end

    assign single  = ((pend & (pend - PEND_ONE)) == '0);
    assign o_valid = (state == SCAN);
    assign o_bin   = o_valid ? hit_idx : '0;
    assign o_last  = o_valid & single;
    assign o_zero  = o_valid & zflag;
    assign beat    = o_valid & i_ready;
    assign o_ready = (state == IDLE) | (beat & o_last);
    assign accept  = i_valid & o_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
            pend  <= '0;
            zflag <= 1'b0;
        end else if (accept) begin
            state <= SCAN;
            pend  <= i_unary;
            zflag <= (i_unary == '0);
        end else if (beat) begin
            pend <= pend & ~clr_mask;
            if (o_last) begin
                state <= IDLE;
                zflag <= 1'b0;
            end
        end
    end

`ifdef STD_BIT_SCAN_ENCODER_COUNT_EN
    localparam logic [BIN_WIDTH:0] CNT_ONE = (BIN_WIDTH + 1)'(1);

    logic [BIN_WIDTH:0] cnt;
    logic [BIN_WIDTH:0] pop;

    always_comb begin
        pop = '0;
        for (int i = 0; i < UNARY_WIDTH; i++) begin
            pop = pop + (BIN_WIDTH + 1)'(i_unary[i]);
        end
    end

    // Loaded at accept so the output path never sees the popcount adder.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= pop;
        end else if (beat && cnt != '0) begin
            cnt <= cnt - CNT_ONE;
        end
    end

    assign o_count = o_valid ? cnt : '0;
`endif

endmodule
